// File: rtl/spi_periph_pkg.sv
// Shared constants and FSM encoding for the SPI peripheral register file.
package spi_periph_pkg;

    localparam int unsigned CMD_W        = 8;
    localparam int unsigned RW_BIT       = 7;
    localparam logic [7:0]  DEF_ID_VALUE = 8'hAA;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } spi_state_t;

endpackage

// File: rtl/spi_periph_regfile_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, plus a history flop
// that yields single-cycle rise/fall pulses in the clk domain.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // Reset to the pin's idle level so leaving reset never looks like an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_hist <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_hist;
    assign o_fall = ~r_sync & r_hist;

endmodule

// File: rtl/spi_periph_regfile.sv
// SPI peripheral with a NUM_REGS x DATA_W register bank, oversampled on clk.
// Optional macro SPI_AUTOINC_EN: address auto-increments after each data word.
module spi_periph_regfile
    import spi_periph_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4,
    parameter bit          CPOL     = 1'b0,
    parameter bit          CPHA     = 1'b0,
    parameter logic [6:0]  ID_ADDR  = 7'h0F,
    parameter logic [7:0]  ID_VALUE = DEF_ID_VALUE
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              sclk,
    input  logic                                              ss_n,
    input  logic                                              mosi,
    output logic                                              miso,
    output logic                                              miso_oe,
    output logic [NUM_REGS*DATA_W-1:0]                        regs_o,
    output logic                                              wr_strobe,
    output logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] wr_addr,
    output logic                                              frame_active
);

    localparam int unsigned AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_ss_lvl, w_ss_rise, w_ss_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sclk (
        .i_clk(clk), .i_rst(rst), .i_async(sclk),
        .o_sync(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .i_clk(clk), .i_rst(rst), .i_async(ss_n),
        .o_sync(w_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(clk), .i_rst(rst), .i_async(mosi),
        .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_sclk_lvl, w_ss_lvl, w_mosi_rise, w_mosi_fall};

    logic w_lead, w_trail, w_sample, w_shift;

    assign w_lead   = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trail  = CPOL ? w_sclk_rise : w_sclk_fall;
    assign w_sample = CPHA ? w_trail : w_lead;
    assign w_shift  = CPHA ? w_lead  : w_trail;

    spi_state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CMD_W-2:0]    r_cmd;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_tx;
    logic [6:0]          r_addr;
    logic                r_rw;
    logic                r_load;
    logic                r_word_pend;
    logic                r_first;
    logic                r_miso;
    logic                r_wr_strobe;
    logic [AW-1:0]       r_wr_addr;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];

    logic                w_last_bit, w_cmd_done, w_word_done, w_rd_data, w_tx_shift;
    logic                w_addr_ok;
    logic [AW-1:0]       w_idx;
    logic [CMD_W-1:0]    w_cmd_next;
    logic [6:0]          w_addr_nxt;
    logic [DATA_W-1:0]   w_load_val;

    assign w_last_bit  = (r_state == CMD) ? (r_bit_cnt == CNT_W'(CMD_W - 1))
                                          : (r_bit_cnt == CNT_W'(DATA_W - 1));
    // A word completing in the same cycle as ss_n rising counts as aborted.
    assign w_cmd_done  = (r_state == CMD)  && w_sample && w_last_bit && !w_ss_rise;
    assign w_word_done = (r_state == DATA) && w_sample && w_last_bit && !w_ss_rise;
    assign w_cmd_next  = {r_cmd, w_mosi};
    assign w_rd_data   = (r_state == DATA) && r_rw;
    assign w_tx_shift  = w_shift && w_rd_data;
    assign w_addr_ok   = (32'(r_addr) < NUM_REGS);
    assign w_idx       = r_addr[AW-1:0];

    always_comb begin
        w_load_val = '0;
        if (w_addr_ok) begin
            w_load_val = r_regs[w_idx];
        end else if (r_addr == ID_ADDR) begin
            w_load_val = DATA_W'(ID_VALUE);
        end
    end

    always_comb begin
        w_addr_nxt = r_addr;
`ifdef SPI_AUTOINC_EN
        if (r_addr == ID_ADDR) begin
            w_addr_nxt = r_addr;
        end else if (32'(r_addr) == NUM_REGS - 1) begin
            w_addr_nxt = '0;
        end else begin
            w_addr_nxt = r_addr + 7'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_ss_fall) w_state_nxt = CMD;
            CMD:     if (w_sample && w_last_bit) w_state_nxt = DATA;
            DATA:    w_state_nxt = DATA;
            default: w_state_nxt = IDLE;
        endcase
        if (w_ss_rise) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_cmd       <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_addr      <= '0;
            r_rw        <= 1'b0;
            r_load      <= 1'b0;
            r_word_pend <= 1'b0;
            r_first     <= 1'b0;
            r_miso      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_wr_strobe <= 1'b0;
            r_load      <= 1'b0;
            r_word_pend <= w_word_done;

            if (r_state == IDLE || w_ss_rise) begin
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
                if (r_state == CMD) begin
                    r_cmd <= w_cmd_next[CMD_W-2:0];
                end else begin
                    r_rx <= {r_rx[DATA_W-2:0], w_mosi};
                end
            end

            if (w_cmd_done) begin
                r_rw   <= w_cmd_next[RW_BIT];
                r_addr <= w_cmd_next[RW_BIT-1:0];
                r_load <= w_cmd_next[RW_BIT];
            end

            // Commit runs one cycle after the word's last sample edge; a read
            // reloads TX one cycle later still, from the already-advanced address.
            if (r_word_pend) begin
                if (!r_rw && w_addr_ok) begin
                    r_regs[w_idx] <= r_rx;
                    r_wr_strobe   <= 1'b1;
                    r_wr_addr     <= w_idx;
                end
                r_addr <= w_addr_nxt;
                r_load <= r_rw;
            end

            if (r_load) begin
                r_tx    <= w_load_val;
                r_first <= 1'b1;
            end else if (w_tx_shift) begin
                if (CPHA) begin
                    r_miso <= r_tx[DATA_W-1];
                    r_tx   <= r_tx << 1;
                end else if (r_first) begin
                    r_first <= 1'b0;
                end else begin
                    r_tx <= r_tx << 1;
                end
            end

            if (!w_rd_data) begin
                r_miso <= 1'b0;
            end
        end
    end

    always_comb begin
        regs_o = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            regs_o[k*DATA_W +: DATA_W] = r_regs[k];
        end
    end

    assign miso         = CPHA ? r_miso : (w_rd_data && !r_load && r_tx[DATA_W-1]);
    assign frame_active = (r_state != IDLE);
    assign miso_oe      = frame_active;
    assign wr_strobe    = r_wr_strobe;
    assign wr_addr      = r_wr_addr;

endmodule

// File: tb/tb_spi_periph_regfile.sv
// Directed bench: one DUT per SPI mode (mode 0 at DATA_W=8, modes 1-3 at 16),
// each driven by a bit-banged master with hand-computed expected values.
module tb_spi_periph_regfile;

    localparam int HALF = 80;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        mosi = 1'b0;
    logic        sclk_w  [4];
    logic        ss_n_w  [4];
    logic        miso_w  [4];
    logic        oe_w    [4];
    logic        strb_w  [4];
    logic        act_w   [4];
    logic [1:0]  waddr_w [4];
    logic [63:0] regs_w  [4];

    int          n_vec = 0;
    int          n_err = 0;
    int          scnt  [4] = '{default: 0};
    logic [1:0]  saddr [4] = '{default: 2'b00};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned DW = (g == 0) ? 8 : 16;
        spi_periph_regfile #(
            .DATA_W   (DW),
            .NUM_REGS (4),
            .CPOL     ((g / 2) == 1),
            .CPHA     ((g % 2) == 1),
            .ID_ADDR  (7'h0F),
            .ID_VALUE (8'hAA)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .sclk         (sclk_w[g]),
            .ss_n         (ss_n_w[g]),
            .mosi         (mosi),
            .miso         (miso_w[g]),
            .miso_oe      (oe_w[g]),
            .regs_o       (regs_w[g][4*DW-1:0]),
            .wr_strobe    (strb_w[g]),
            .wr_addr      (waddr_w[g]),
            .frame_active (act_w[g])
        );
        if (DW < 16) begin : g_pad
            assign regs_w[g][63:4*DW] = '0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (strb_w[k] === 1'b1) begin
                scnt[k]++;
                saddr[k] = waddr_w[k];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic frame_open(input int m);
        ss_n_w[m] = 1'b0;
        #(HALF);
    endtask

    task automatic frame_close(input int m);
        #(HALF);
        ss_n_w[m] = 1'b1;
        #(2 * HALF);
    endtask

    // Master shifts n bits MSB first and captures miso at its own sample edge.
    task automatic xfer(input int m, input int n, input logic [31:0] dout,
                        output logic [31:0] din);
        logic cpol;
        logic cpha;
        cpol = (m >= 2);
        cpha = ((m % 2) == 1);
        din  = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi = dout[i];
                #(HALF);
                din = {din[30:0], miso_w[m]};
                sclk_w[m] = ~cpol;
                #(HALF);
                sclk_w[m] = cpol;
            end else begin
                sclk_w[m] = ~cpol;
                mosi = dout[i];
                #(HALF);
                din = {din[30:0], miso_w[m]};
                sclk_w[m] = cpol;
                #(HALF);
            end
        end
    endtask

    task automatic run(input int m, input int dw, input logic [7:0] cmd,
                       input logic [31:0] wdat, output logic [31:0] rc,
                       output logic [31:0] rd);
        frame_open(m);
        xfer(m, 8, {24'h0, cmd}, rc);
        xfer(m, dw, wdat, rd);
        frame_close(m);
    endtask

    logic [31:0] rc, rd, rd2;

    initial begin
        for (int m = 0; m < 4; m++) begin
            sclk_w[m] = (m >= 2);
            ss_n_w[m] = 1'b1;
        end
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #20;

        chk("rst_regs",  regs_w[0], 64'h0);
        chk("rst_miso",  miso_w[0], 1'b0);
        chk("rst_oe",    oe_w[0],   1'b0);
        chk("rst_strb",  strb_w[0], 1'b0);
        chk("rst_waddr", waddr_w[0], 2'd0);
        chk("rst_act",   act_w[0],  1'b0);
        chk("rst_regs_m3", regs_w[3], 64'h0);

        run(0, 8, 8'h01, 32'h5A, rc, rd);
        chk("wr1_strobes", scnt[0], 1);
        chk("wr1_addr",    saddr[0], 2'd1);
        chk("wr1_regs",    regs_w[0], 64'h0000_5A00);
        chk("wr1_miso",    {rc, rd}, 64'h0);

        frame_open(0);
        chk("rd1_oe_in",  oe_w[0],  1'b1);
        chk("rd1_act_in", act_w[0], 1'b1);
        xfer(0, 8, 32'h81, rc);
        xfer(0, 8, 32'h00, rd);
        frame_close(0);
        chk("rd1_data",    rd, 32'h5A);
        chk("rd1_cmd_miso", rc, 32'h0);
        chk("rd1_oe_out",  oe_w[0], 1'b0);
        chk("rd1_strobes", scnt[0], 1);

        run(0, 8, 8'h8F, 32'h0, rc, rd);
        chk("id_read", rd, 32'hAA);
        run(0, 8, 8'h0F, 32'h33, rc, rd);
        chk("id_wr_strobes", scnt[0], 1);
        chk("id_wr_regs",    regs_w[0], 64'h0000_5A00);
        run(0, 8, 8'h90, 32'h0, rc, rd);
        chk("bad_addr_read", rd, 32'h0);

        frame_open(0);
        xfer(0, 8, 32'h00, rc);
        xfer(0, 5, 32'h1F, rd);
        frame_close(0);
        chk("abort_strobes", scnt[0], 1);
        chk("abort_regs",    regs_w[0], 64'h0000_5A00);
        run(0, 8, 8'h00, 32'hC3, rc, rd);
        chk("post_abort_strobes", scnt[0], 2);
        chk("post_abort_addr",    saddr[0], 2'd0);
        chk("post_abort_regs",    regs_w[0], 64'h0000_5AC3);

        frame_open(0);
        xfer(0, 8, 32'h03, rc);
        xfer(0, 8, 32'h11, rd);
        xfer(0, 8, 32'h22, rd);
        frame_close(0);
        chk("burst_strobes", scnt[0], 4);
`ifdef SPI_AUTOINC_EN
        chk("burst_regs", regs_w[0], 64'h1100_5A22);
        chk("burst_addr", saddr[0], 2'd0);
`else
        chk("burst_regs", regs_w[0], 64'h2200_5AC3);
        chk("burst_addr", saddr[0], 2'd3);
`endif

        frame_open(0);
        xfer(0, 8, 32'h81, rc);
        xfer(0, 8, 32'h00, rd);
        xfer(0, 8, 32'h00, rd2);
        frame_close(0);
        chk("rd2_word0", rd, 32'h5A);
`ifdef SPI_AUTOINC_EN
        chk("rd2_word1", rd2, 32'h00);
`else
        chk("rd2_word1", rd2, 32'h5A);
`endif

        for (int m = 1; m < 4; m++) begin
            run(m, 16, 8'h02, 32'hBEEF, rc, rd);
            chk($sformatf("m%0d_wr_strobes", m), scnt[m], 1);
            chk($sformatf("m%0d_wr_addr", m),    saddr[m], 2'd2);
            chk($sformatf("m%0d_regs", m),       regs_w[m], 64'h0000_BEEF_0000_0000);
            run(m, 16, 8'h82, 32'h0, rc, rd);
            chk($sformatf("m%0d_rd_data", m),    rd, 32'hBEEF);
            chk($sformatf("m%0d_rd_oe_out", m),  oe_w[m], 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
